sram_ctrl: RTL

Synchronous controller that turns single-request word accesses from the core-side memory interface into correctly sequenced cycles on an external asynchronous 16-bit SRAM with active-low chip select, write enable, output enable and per-byte lane selects. It generalises the plain SRAM access path to configurable word width (multiple 16-bit beats per request), configurable access wait states and per-byte write masking. It sits between the data-memory port of the multithreaded core and the off-chip SRAM pins.

---
 rtl/sram_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences core word requests into multi-beat cycles on an
// asynchronous 16-bit SRAM (SETUP / ACCESS / HOLD per beat) with
// configurable wait states and per-byte write masking.
// DATA_W must be a multiple of 16; WAIT_CYCLES must be at least 1.
module sram_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 20,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_be,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  sram_cs_n,
   output logic                  sram_we_n,
   output logic                  sram_oe_n,
   output logic                  sram_lb_n,
   output logic                  sram_ub_n,
   output logic [ADDR_W-1:0]     sram_addr,
   inout  wire  [15:0]           sram_dq
);

   localparam int BEATS  = DATA_W / 16;
   localparam int BE_W   = DATA_W / 8;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   state_t              state_q;
   logic [BEAT_W-1:0]   beat_q;
   logic [WAIT_W-1:0]   wait_q;
   logic                op_we_q;
   logic [ADDR_W-1:0]   base_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [BE_W-1:0]     be_q;
   logic [DATA_W-1:0]   rdbuf_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic                rsp_valid_q;
   logic                ready_q;
   logic                cs_n_q;
   logic                we_n_q;
   logic                oe_n_q;
   logic                lb_n_q;
   logic                ub_n_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                dq_oe_q;
   logic [15:0]         dq_out_q;

   // Source of the next SETUP beat: fresh request from IDLE, latched request otherwise
   logic                setup_we_d;
   logic [ADDR_W-1:0]   setup_base_d;
   logic [DATA_W-1:0]   setup_wdata_d;
   logic [BE_W-1:0]     setup_be_d;
   logic [BEAT_W-1:0]   setup_beat_d;
   logic [ADDR_W-1:0]   setup_addr_d;
   logic [15:0]         setup_dq_d;
   logic                setup_lb_n_d;
   logic                setup_ub_n_d;

   // Select where the next beat's fields come from
   always_comb begin
      setup_we_d    = op_we_q;
      setup_base_d  = base_q;
      setup_wdata_d = wdata_q;
      setup_be_d    = be_q;
      setup_beat_d  = beat_q + 1'b1;
      if (state_q == S_IDLE) begin
         setup_we_d    = req_we;
         setup_base_d  = req_addr;
         setup_wdata_d = req_wdata;
         setup_be_d    = req_be;
         setup_beat_d  = '0;
      end
   end

   // Derive beat address (wraps modulo 2^ADDR_W), beat data and lane selects
   always_comb begin
      int idx;
      idx          = int'(setup_beat_d);
      setup_addr_d = setup_base_d + ADDR_W'(setup_beat_d);
      setup_dq_d   = setup_wdata_d[16*idx +: 16];
      setup_lb_n_d = 1'b0;
      setup_ub_n_d = 1'b0;
      if (setup_we_d) begin
         setup_lb_n_d = ~setup_be_d[2*idx];
         setup_ub_n_d = ~setup_be_d[2*idx+1];
      end
   end

   // Main sequencer: state, beat/wait counters and all registered SRAM pins
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         wait_q      <= '0;
         op_we_q     <= 1'b0;
         rdbuf_q     <= '0;
         rsp_rdata_q <= '0;
         rsp_valid_q <= 1'b0;
         ready_q     <= 1'b0;
         cs_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         lb_n_q      <= 1'b1;
         ub_n_q      <= 1'b1;
         addr_q      <= '0;
         dq_oe_q     <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid && ready_q) begin
                  op_we_q  <= req_we;
                  base_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  be_q     <= req_be;
                  beat_q   <= '0;
                  ready_q  <= 1'b0;
                  state_q  <= S_SETUP;
                  cs_n_q   <= 1'b0;
                  we_n_q   <= 1'b1;
                  oe_n_q   <= 1'b1;
                  addr_q   <= setup_addr_d;
                  lb_n_q   <= setup_lb_n_d;
                  ub_n_q   <= setup_ub_n_d;
                  dq_out_q <= setup_dq_d;
                  dq_oe_q  <= req_we;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            S_SETUP: begin
               state_q <= S_ACCESS;
               wait_q  <= '0;
               if (op_we_q) begin
                  // A beat with no byte enabled runs its timing but never strobes
                  we_n_q <= lb_n_q & ub_n_q;
               end else begin
                  oe_n_q <= 1'b0;
               end
            end
            S_ACCESS: begin
               if (wait_q == WAIT_W'(WAIT_CYCLES - 1)) begin
                  state_q <= S_HOLD;
                  we_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  if (!op_we_q) begin
                     rdbuf_q[16*int'(beat_q) +: 16] <= sram_dq;
                  end
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            S_HOLD: begin
               if (beat_q == BEAT_W'(BEATS - 1)) begin
                  state_q     <= S_IDLE;
                  cs_n_q      <= 1'b1;
                  lb_n_q      <= 1'b1;
                  ub_n_q      <= 1'b1;
                  dq_oe_q     <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  ready_q     <= 1'b1;
                  if (!op_we_q) begin
                     rsp_rdata_q <= rdbuf_q;
                  end
               end else begin
                  state_q  <= S_SETUP;
                  beat_q   <= setup_beat_d;
                  addr_q   <= setup_addr_d;
                  lb_n_q   <= setup_lb_n_d;
                  ub_n_q   <= setup_ub_n_d;
                  dq_out_q <= setup_dq_d;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign sram_cs_n = cs_n_q;
   assign sram_we_n = we_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_lb_n = lb_n_q;
   assign sram_ub_n = ub_n_q;
   assign sram_addr = addr_q;
   assign sram_dq   = dq_oe_q ? dq_out_q : 16'hzzzz;

endmodule
